mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage pipeline. It sits between EX and WB and latches ex_to_mem_bus.
//  It waits on the variable-latency data SRAM read response and raises a stall request while a load is outstanding.
//  It aligns and extends load data, then drives mem_to_wb_bus into WB and a forwarding bus into ID.
// PARAMETERS
//  EX_TO_MEM_WD   79  {pc[78:47],ram_en[46],ram_wen[45:42],sel_rf_res[41],rf_we[40],rf_waddr[39:35],ex_result[34:3],load_type[2:0]}
//  MEM_TO_WB_WD   70  {pc[69:38],rf_we[37],rf_waddr[36:32],rf_wdata[31:0]}
//  MEM_TO_ID_WD   39  {load_pending[38],rf_we[37],rf_waddr[36:32],rf_wdata[31:0]}
//  STALL_WD        6  stall bus width; Stop=1'b1, NoStop=1'b0
// PORTS
//  clk                 in   1    clock, all state on posedge
//  rst                 in   1    asynchronous reset, active-low
//  stall               in   6    pipeline stall bus; [3]=MEM, [4]=WB
//  flush               in   1    synchronous kill of MEM contents
//  ex_to_mem_bus       in   79   EX results
//  data_sram_rdata     in   32   read data, valid only when rdata_ok=1
//  data_sram_rdata_ok  in   1    one-cycle pulse per read response, in request order
//  mem_to_wb_bus       out  70   to WB register
//  mem_to_id_bus       out  39   forwarding/hazard info to ID
//  stallreq_mem        out  1    1 = load data not yet available
// BEHAVIOUR
//  Pipe register r (the ex_to_mem_bus capture register):
//   - rst=0 clears r asynchronously.
//   - Otherwise, on each posedge, in priority order:
//     - flush: r<=0.
//     - stall[3]=Stop and stall[4]=NoStop: r<=0 (bubble).
//     - stall[3]=NoStop: r<=ex_to_mem_bus.
//     - else: hold r.
//  Load condition: is_load = ram_en & (ram_wen==0).
//  Load FSM, states IDLE/WAIT/DONE, reset to IDLE. Also a 32b buffer rbuf (reset 0) and a discard flag (reset 0).
//   - IDLE: is_load & !ok_eff & !flush -> WAIT.
//     is_load & ok_eff & stall[3]=Stop -> DONE, rbuf<=rdata. Otherwise stay in IDLE.
//   - WAIT: ok_eff & stall[3]=NoStop -> IDLE. ok_eff & stall[3]=Stop -> DONE, rbuf<=rdata. !ok_eff -> stay.
//   - DONE: stall[3]=NoStop -> IDLE.
//   - flush in any state -> IDLE. If flush hits WAIT with no ok that cycle, discard<=1.
//  ok_eff = rdata_ok & !discard. While discard=1, the next rdata_ok is consumed: discard<=0 and the data is dropped.
//  rdata_ok in IDLE with no load and no discard pending is ignored.
//  Data select: rdat = (state==DONE) ? rbuf : data_sram_rdata.
//  stallreq_mem = is_load & !(ok_eff | state==DONE). It is combinational, so an ok_eff pulse releases the stall the same cycle.
//  Load extract, using a = ex_result[1:0]:
//   - 000 lw: rdat.
//   - 001 lb: sign-extended byte a.
//   - 010 lbu: zero-extended byte a.
//   - 011 lh: sign-extended half a[1].
//   - 100 lhu: zero-extended half a[1].
//   - other codes: rdat.
//  Byte a=0 is rdat[7:0] (little-endian).
//  rf_wdata = sel_rf_res ? load_data : ex_result.
//  rf_we_o = rf_we & !stallreq_mem.
//  mem_to_wb_bus = {pc, rf_we_o, rf_waddr, rf_wdata}.
//  mem_to_id_bus = {stallreq_mem & rf_we, rf_we_o, rf_waddr, rf_wdata}. load_pending tells ID to stall rather than forward.
//  Reset values: r=0, so both buses are 0 and stallreq_mem=0.
//  Latency: a non-load is forwarded the cycle after capture. A load completes in the ok_eff cycle, 0 extra cycles if ok comes immediately.
//  Reset mid-WAIT: FSM->IDLE, discard->0. Responses arriving after reset are ignored because r is empty.
// TESTING
//  1) Non-load: ex_result=0x12345678, rf_we=1, waddr=5, sel=0 -> next cycle WB bus we=1, addr=5, data=0x12345678, stallreq=0.
//  2) lb a=3, rdata_ok pulsed 3 cycles late with 0x80345678 -> stallreq=1 for 3 cycles, then wdata=0xFFFFFF80.
//  3) lhu a=2, immediate ok with 0xBEEF1234, while stall[3]=Stop for 2 cycles -> DONE holds, wdata=0x0000BEEF stable, stallreq=0.
//  4) flush in WAIT, next load issued; stale ok(0xDEAD0000) then ok(0x000000AA) for lbu a=0 -> stale one dropped, wdata=0x000000AA.
//  5) rst=0 asserted mid-WAIT (async, between edges) -> buses=0, stallreq=0 immediately; after release, a lone rdata_ok is ignored.
//  6) stall[3]=Stop, stall[4]=NoStop with no load -> r cleared at next edge, WB bus=0 (bubble).

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: latches EX results, waits on the variable-latency data SRAM read,
// aligns/extends load data and drives the WB register and the ID forwarding bus.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70,
    parameter int MEM_TO_ID_WD = 39,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic                    flush,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_rdata_ok,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    stallreq_mem
);

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    logic [EX_TO_MEM_WD-1:0] r;
    state_t                  state, state_nxt;
    logic [31:0]             rbuf, rbuf_nxt;
    logic                    discard, discard_nxt;

    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [2:0]  load_type;

    logic        is_load;
    logic        ok_eff;
    logic [31:0] rdat;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        rf_we_o;
    logic        unused_stall_bits;

    assign {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result, load_type} = r;
    assign unused_stall_bits = ^{stall[STALL_WD-1:5], stall[2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
        end else if (flush) begin
            r <= '0;
        end else if (stall[3] == STOP && stall[4] == NO_STOP) begin
            r <= '0;
        end else if (stall[3] == NO_STOP) begin
            r <= ex_to_mem_bus;
        end
    end

    assign is_load = ram_en && (ram_wen == 4'd0);
    assign ok_eff  = data_sram_rdata_ok && !discard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            rbuf    <= '0;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            rbuf    <= rbuf_nxt;
            discard <= discard_nxt;
        end
    end

    // A flushed outstanding read still returns one response; discard swallows it.
    always_comb begin
        state_nxt   = state;
        rbuf_nxt    = rbuf;
        discard_nxt = discard;
        if (data_sram_rdata_ok && discard) begin
            discard_nxt = 1'b0;
        end
        case (state)
            ST_IDLE: begin
                if (is_load && !ok_eff && !flush) begin
                    state_nxt = ST_WAIT;
                end else if (is_load && ok_eff && stall[3] == STOP) begin
                    state_nxt = ST_DONE;
                    rbuf_nxt  = data_sram_rdata;
                end
            end
            ST_WAIT: begin
                if (ok_eff) begin
                    if (stall[3] == STOP) begin
                        state_nxt = ST_DONE;
                        rbuf_nxt  = data_sram_rdata;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (stall[3] == NO_STOP) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
            if (state == ST_WAIT && !ok_eff) begin
                discard_nxt = 1'b1;
            end
        end
    end

    assign rdat         = (state == ST_DONE) ? rbuf : data_sram_rdata;
    assign stallreq_mem = is_load && !(ok_eff || state == ST_DONE);

    always_comb begin
        case (ex_result[1:0])
            2'd0:    byte_val = rdat[7:0];
            2'd1:    byte_val = rdat[15:8];
            2'd2:    byte_val = rdat[23:16];
            default: byte_val = rdat[31:24];
        endcase
        half_val = ex_result[1] ? rdat[31:16] : rdat[15:0];
        case (load_type)
            3'b001:  load_data = {{24{byte_val[7]}}, byte_val};
            3'b010:  load_data = {24'd0, byte_val};
            3'b011:  load_data = {{16{half_val[15]}}, half_val};
            3'b100:  load_data = {16'd0, half_val};
            default: load_data = rdat;
        endcase
    end

    assign rf_wdata      = sel_rf_res ? load_data : ex_result;
    assign rf_we_o       = rf_we && !stallreq_mem;
    assign mem_to_wb_bus = {pc, rf_we_o, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {stallreq_mem && rf_we, rf_we_o, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized load/non-load traffic,
// each cycle compared against a transaction-level reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [78:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rdata_ok;
    logic [69:0] mem_to_wb_bus;
    logic [38:0] mem_to_id_bus;
    logic        stallreq_mem;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction sitting in MEM, whether its load data is
    // already buffered, whether it has waited, and how many stale responses remain.
    logic [78:0] m_r;
    logic        m_have;
    logic [31:0] m_rbuf;
    logic        m_waited;
    int          m_stale;

    localparam logic [5:0] GO     = 6'b000000;
    localparam logic [5:0] HOLD   = 6'b011111;
    localparam logic [5:0] BUBBLE = 6'b001111;

    mem_stage dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .flush              (flush),
        .ex_to_mem_bus      (ex_to_mem_bus),
        .data_sram_rdata    (data_sram_rdata),
        .data_sram_rdata_ok (data_sram_rdata_ok),
        .mem_to_wb_bus      (mem_to_wb_bus),
        .mem_to_id_bus      (mem_to_id_bus),
        .stallreq_mem       (stallreq_mem)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [78:0] mk_bus(logic [31:0] pc, logic en, logic [3:0] wen, logic sel,
                                           logic we, logic [4:0] waddr, logic [31:0] res, logic [2:0] lt);
        return {pc, en, wen, sel, we, waddr, res, lt};
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] lt, logic [1:0] a, logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a)) & 32'h0000_00FF;
        h = (d >> (16 * a[1])) & 32'h0000_FFFF;
        case (lt)
            3'b001:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b010:  return b;
            3'b011:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return h;
            default: return d;
        endcase
    endfunction

    task automatic modelReset();
        m_r      = '0;
        m_have   = 1'b0;
        m_rbuf   = '0;
        m_waited = 1'b0;
        m_stale  = 0;
    endtask

    task automatic checkAll(input string tag);
        logic        ld, oke, sr, we;
        logic [31:0] d, wdata;
        ld    = m_r[46] && (m_r[45:42] == 4'd0);
        oke   = data_sram_rdata_ok && (m_stale == 0);
        d     = m_have ? m_rbuf : data_sram_rdata;
        sr    = ld && !(oke || m_have);
        wdata = m_r[41] ? ref_load(m_r[2:0], m_r[4:3], d) : m_r[34:3];
        we    = m_r[40] && !sr;
        checkOutput({tag, ".wb"}, 80'(mem_to_wb_bus), 80'({m_r[78:47], we, m_r[39:35], wdata}));
        checkOutput({tag, ".id"}, 80'(mem_to_id_bus), 80'({sr && m_r[40], we, m_r[39:35], wdata}));
        checkOutput({tag, ".stallreq"}, 80'(stallreq_mem), 80'(sr));
    endtask

    task automatic modelStep();
        logic        ld, oke, nh, nw;
        logic [31:0] nb;
        if (!rst) begin
            modelReset();
            return;
        end
        ld  = m_r[46] && (m_r[45:42] == 4'd0);
        oke = data_sram_rdata_ok && (m_stale == 0);
        nh  = m_have;
        nb  = m_rbuf;
        if (flush) nh = 1'b0;
        else if (m_have) nh = stall[3];
        else if (ld && oke && stall[3]) begin
            nh = 1'b1;
            nb = data_sram_rdata;
        end
        nw = !flush && !m_have && ld && !oke;
        if (flush && m_waited && !oke) m_stale = 1;
        else if (data_sram_rdata_ok && m_stale > 0) m_stale--;
        m_have   = nh;
        m_rbuf   = nb;
        m_waited = nw;
        if (flush) m_r = '0;
        else if (stall[3] && !stall[4]) m_r = '0;
        else if (!stall[3]) m_r = ex_to_mem_bus;
    endtask

    task automatic applyStimulus(input string tag, input logic [78:0] bus, input logic [5:0] st,
                                 input logic fl, input logic ok, input logic [31:0] rd);
        ex_to_mem_bus      = bus;
        stall              = st;
        flush              = fl;
        data_sram_rdata_ok = ok;
        data_sram_rdata    = rd;
        #4;
        checkAll(tag);
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic doLoad(input string tag, input logic [2:0] lt, input logic [1:0] a, input logic [31:0] d,
                          input int lat, input int hold, input logic stale);
        logic [78:0] bus;
        bus = mk_bus($urandom, 1'b1, 4'd0, 1'b1, 1'b1, 5'($urandom), {30'($urandom), a}, lt);
        applyStimulus(tag, bus, GO, 1'b0, 1'b0, $urandom);
        if (stale) applyStimulus(tag, bus, GO, 1'b0, 1'b1, 32'hDEAD_0000);
        for (int i = 0; i < lat; i++) applyStimulus(tag, bus, GO, 1'b0, 1'b0, $urandom);
        if (hold > 0) begin
            applyStimulus(tag, bus, HOLD, 1'b0, 1'b1, d);
            for (int i = 1; i < hold; i++) applyStimulus(tag, bus, HOLD, 1'b0, 1'b0, $urandom);
            applyStimulus(tag, '0, GO, 1'b0, 1'b0, $urandom);
        end else begin
            applyStimulus(tag, '0, GO, 1'b0, 1'b1, d);
        end
    endtask

    task automatic doFlushedLoad(input string tag);
        logic [78:0] bus;
        bus = mk_bus($urandom, 1'b1, 4'd0, 1'b1, 1'b1, 5'($urandom), $urandom, 3'($urandom_range(0, 4)));
        applyStimulus(tag, bus, GO, 1'b0, 1'b0, $urandom);
        applyStimulus(tag, bus, GO, 1'b0, 1'b0, $urandom);
        applyStimulus(tag, bus, GO, 1'b1, 1'b0, $urandom);
    endtask

    initial begin
        logic [78:0] bus;
        int          kind;
        rst = 1'b0;
        stall = GO;
        flush = 1'b0;
        ex_to_mem_bus = '0;
        data_sram_rdata = '0;
        data_sram_rdata_ok = 1'b0;
        modelReset();
        @(negedge clk);
        applyStimulus("reset", mk_bus(32'h1, 1'b1, 4'd0, 1'b1, 1'b1, 5'd3, 32'h4, 3'd0), GO, 1'b0, 1'b1, 32'h55);
        rst = 1'b1;

        applyStimulus("nonload", mk_bus(32'hBFC0_0000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 3'd0),
                      GO, 1'b0, 1'b0, 32'h0);
        applyStimulus("nonload_next", '0, GO, 1'b0, 1'b0, 32'h0);

        doLoad("lb_late", 3'b001, 2'd3, 32'h8034_5678, 3, 0, 1'b0);
        doLoad("lhu_hold", 3'b100, 2'd2, 32'hBEEF_1234, 0, 2, 1'b0);
        doFlushedLoad("flush_wait");
        doLoad("lbu_after_flush", 3'b010, 2'd0, 32'h0000_00AA, 1, 0, 1'b1);

        bus = mk_bus($urandom, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, 32'h0000_0000, 3'd0);
        applyStimulus("rst_wait", bus, GO, 1'b0, 1'b0, $urandom);
        applyStimulus("rst_wait", bus, GO, 1'b0, 1'b0, $urandom);
        #1 rst = 1'b0;
        #1 modelReset();
        checkAll("rst_async");
        #1 rst = 1'b1;
        ex_to_mem_bus = '0;
        data_sram_rdata_ok = 1'b0;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        applyStimulus("rst_lone_ok", '0, GO, 1'b0, 1'b1, 32'hCAFE_F00D);
        applyStimulus("rst_after", '0, GO, 1'b0, 1'b0, 32'h0);

        applyStimulus("bubble_pre", mk_bus($urandom, 1'b0, 4'd0, 1'b0, 1'b1, 5'd7, $urandom, 3'd0),
                      GO, 1'b0, 1'b0, 32'h0);
        applyStimulus("bubble", mk_bus($urandom, 1'b0, 4'd0, 1'b0, 1'b1, 5'd8, $urandom, 3'd0),
                      BUBBLE, 1'b0, 1'b0, 32'h0);
        applyStimulus("bubble_out", '0, GO, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 3) begin
                bus = mk_bus($urandom, 1'($urandom), 4'($urandom_range(1, 15)), 1'($urandom), 1'($urandom),
                             5'($urandom), $urandom, 3'($urandom));
                if (!bus[46]) bus[45:42] = 4'd0;
                applyStimulus("rand_nonload", bus, ($urandom_range(0, 4) == 0) ? BUBBLE : GO, 1'b0,
                              ($urandom_range(0, 3) == 0), $urandom);
            end else if (kind < 9) begin
                doLoad("rand_load", 3'($urandom), 2'($urandom), $urandom, $urandom_range(0, 3),
                       $urandom_range(0, 2), 1'b0);
            end else begin
                doFlushedLoad("rand_flush");
                doLoad("rand_stale", 3'($urandom), 2'($urandom), $urandom, $urandom_range(0, 2), 0, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
